mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 106 ++++++++++
 tb/tb_mem_copy_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Word-at-a-time memory copy/fill engine: streams N words from a latency-RD_LAT
// source memory (or a constant fill word) to a destination memory, one per cycle.
module mem_copy_engine #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] number_words,
  input  logic [DATA_W-1:0] fill_value,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   rd_ptr, wr_ptr, rd_left, wr_left;
  logic                mode_q;
  logic [DATA_W-1:0]   fill_q;
  logic [RD_LAT-1:0]   vld_d;
  logic                accept, issue, cap;

  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    issue  = (state == RUN) && (rd_left != '0);
    // Fill words need no read, so they skip the read-latency delay line.
    cap    = mode_q ? issue : vld_d[RD_LAT-1];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (rd_left == '0) state_nx = DONE;
               else if (rd_left == ONE) state_nx = DRAIN;
      DRAIN:   if (write_en && wr_left == ONE) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    read_en      = issue && !mode_q;
    read_address = rd_ptr;
    busy         = (state == RUN) || (state == DRAIN);
    done         = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      rd_left       <= '0;
      wr_left       <= '0;
      mode_q        <= 1'b0;
      fill_q        <= '0;
      vld_d         <= '0;
      write_en      <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      if (accept) begin
        rd_ptr  <= src_base;
        wr_ptr  <= dst_base;
        rd_left <= number_words;
        wr_left <= number_words;
        mode_q  <= mode;
        fill_q  <= fill_value;
      end else begin
        if (issue) begin
          rd_ptr  <= rd_ptr + ONE;
          rd_left <= rd_left - ONE;
        end
        if (write_en) wr_left <= wr_left - ONE;
        if (cap)      wr_ptr  <= wr_ptr + ONE;
      end
      vld_d[0] <= issue && !mode_q;
      for (int unsigned k = 1; k < RD_LAT; k++) vld_d[k] <= vld_d[k-1];
      write_en <= cap;
      if (cap) begin
        write_address <= wr_ptr;
        write_data    <= mode_q ? fill_q : read_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench: two engines (RD_LAT=1 and RD_LAT=3) against behavioural memories.
module tb_mem_copy_engine;
  localparam int AW = 9;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic          mode;
  logic [AW-1:0] src_base, dst_base, number_words;
  logic [DW-1:0] fill_value;
  logic          start1, start3;

  logic re1, we1, busy1, done1, re3, we3, busy3, done3;
  logic [AW-1:0] ra1, wa1, ra3, wa3;
  logic [DW-1:0] rd1, wd1, rd3, wd3;

  logic [DW-1:0] mem [0:511];
  logic [DW-1:0] rp1, rp3_0, rp3_1, rp3_2;

  mem_copy_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .number_words(number_words), .fill_value(fill_value),
    .read_en(re1), .read_address(ra1), .read_data(rd1), .write_en(we1),
    .write_address(wa1), .write_data(wd1), .busy(busy1), .done(done1));

  mem_copy_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .number_words(number_words), .fill_value(fill_value),
    .read_en(re3), .read_address(ra3), .read_data(rd3), .write_en(we3),
    .write_address(wa3), .write_data(wd3), .busy(busy3), .done(done3));

  always @(posedge clk) begin
    rp1   <= re1 ? mem[ra1] : '0;
    rp3_0 <= re3 ? mem[ra3] : '0;
    rp3_1 <= rp3_0;
    rp3_2 <= rp3_1;
  end
  assign rd1 = rp1;
  assign rd3 = rp3_2;

  typedef struct {
    int unsigned   t;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ev_t;

  ev_t rq1[$], wq1[$], rq3[$], wq3[$];
  ev_t e1, e3;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (re1) begin
      if (rq1.size() == 0) chk("u1 unexpected read_en", re1, 0);
      else begin
        e1 = rq1.pop_front();
        chk("u1 read cycle", cyc, e1.t);
        chk("u1 read_address", ra1, e1.a);
      end
    end
    if (we1) begin
      if (wq1.size() == 0) chk("u1 unexpected write_en", we1, 0);
      else begin
        e1 = wq1.pop_front();
        chk("u1 write cycle", cyc, e1.t);
        chk("u1 write_address", wa1, e1.a);
        chk("u1 write_data", wd1, e1.d);
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (re3) begin
      if (rq3.size() == 0) chk("u3 unexpected read_en", re3, 0);
      else begin
        e3 = rq3.pop_front();
        chk("u3 read cycle", cyc, e3.t);
        chk("u3 read_address", ra3, e3.a);
      end
    end
    if (we3) begin
      if (wq3.size() == 0) chk("u3 unexpected write_en", we3, 0);
      else begin
        e3 = wq3.pop_front();
        chk("u3 write cycle", cyc, e3.t);
        chk("u3 write_address", wa3, e3.a);
        chk("u3 write_data", wd3, e3.d);
      end
    end
  end

  // Called just after a falling edge; t0 is the cyc value during cycle 1.
  task automatic go(input int sel, input logic m, input logic [AW-1:0] s,
                    input logic [AW-1:0] d, input logic [AW-1:0] n,
                    input logic [DW-1:0] f, output int unsigned t0);
    ev_t e;
    int unsigned lat;
    mode = m; src_base = s; dst_base = d; number_words = n; fill_value = f;
    if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
    t0  = cyc + 1;
    lat = (sel == 1) ? 1 : 3;
    for (int unsigned i = 0; i < n; i++) begin
      if (!m) begin
        e.t = t0 + i; e.a = s + AW'(i); e.d = '0;
        if (sel == 1) rq1.push_back(e); else rq3.push_back(e);
        e.t = t0 + i + 1 + lat; e.d = mem[e.a]; e.a = d + AW'(i);
      end else begin
        e.t = t0 + i + 1; e.a = d + AW'(i); e.d = f;
      end
      if (sel == 1) wq1.push_back(e); else wq3.push_back(e);
    end
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic at(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done(input int sel);
    int k = 0;
    while (!(sel == 1 ? done1 : done3) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done reached", (sel == 1) ? done1 : done3, 1);
    chk("reads outstanding", (sel == 1) ? rq1.size() : rq3.size(), 0);
    chk("writes outstanding", (sel == 1) ? wq1.size() : wq3.size(), 0);
  endtask

  task automatic chk_reset_u1(input string tag);
    chk({tag, " read_en"}, re1, 0);
    chk({tag, " write_en"}, we1, 0);
    chk({tag, " busy"}, busy1, 0);
    chk({tag, " done"}, done1, 0);
    chk({tag, " read_address"}, ra1, 0);
    chk({tag, " write_address"}, wa1, 0);
    chk({tag, " write_data"}, wd1, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    mode = 0; src_base = '0; dst_base = '0; number_words = '0; fill_value = '0;
    start1 = 0; start3 = 0;
    for (int a = 0; a < 512; a++) mem[a] = 64'hC0DE_0000_0000_0000 | (64'(a) * 64'h1_0001);
    for (int i = 0; i < 4; i++) mem[16 + i] = 64'hA0 + 64'(i);

    repeat (2) @(negedge clk);
    chk_reset_u1("reset u1");
    chk("reset u3 busy", busy3, 0);
    chk("reset u3 done", done3, 0);
    rst = 0;
    @(negedge clk);

    // Copy N=4, RD_LAT=1; a start with new inputs in cycle 2 must be ignored.
    go(1, 0, 9'h010, 9'h100, 9'd4, '0, t0);
    chk("copy busy c1", busy1, 1);
    chk("copy done c1", done1, 0);
    at(t0 + 1);
    mode = 1; src_base = 9'h055; dst_base = 9'h077; number_words = 9'd9; fill_value = '1;
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    at(t0 + 5);
    chk("copy busy c6", busy1, 1);
    chk("copy done c6", done1, 0);
    at(t0 + 6);
    chk("copy busy c7", busy1, 0);
    chk("copy done c7", done1, 1);
    wait_done(1);

    // RD_LAT=3, N=2: writes in cycles 5,6.
    go(3, 0, 9'h040, 9'h080, 9'd2, '0, t0);
    chk("lat3 busy c1", busy3, 1);
    at(t0 + 5);
    chk("lat3 busy c6", busy3, 1);
    chk("lat3 done c6", done3, 0);
    at(t0 + 6);
    chk("lat3 busy c7", busy3, 0);
    chk("lat3 done c7", done3, 1);
    wait_done(3);

    go(1, 0, 9'h1FE, 9'h1FF, 9'd3, '0, t0);
    wait_done(1);

    // Fill N=3 from a DONE state.
    go(1, 1, 9'h000, 9'h020, 9'd3, 64'hDEAD_BEEF_0000_0001, t0);
    at(t0 + 3);
    chk("fill busy c4", busy1, 1);
    at(t0 + 4);
    chk("fill busy c5", busy1, 0);
    chk("fill done c5", done1, 1);
    wait_done(1);

    go(3, 1, 9'h000, 9'h1FF, 9'd2, 64'h0123_4567_89AB_CDEF, t0);
    wait_done(3);

    // Zero length with a start pulse during the single RUN cycle.
    go(1, 0, 9'h030, 9'h030, 9'd0, '0, t0);
    chk("zero busy c1", busy1, 1);
    chk("zero done c1", done1, 0);
    number_words = 9'd5; start1 = 1;
    @(negedge clk);
    start1 = 0;
    chk("zero done c2", done1, 1);
    chk("zero busy c2", busy1, 0);
    @(negedge clk);
    chk("zero done c3", done1, 1);
    wait_done(1);

    // Reset during word 2 of an N=8 copy, then a clean N=1 copy.
    go(1, 0, 9'h000, 9'h0C0, 9'd8, '0, t0);
    at(t0 + 4);
    #2 rst = 1;
    #1 chk_reset_u1("midrst");
    rq1.delete();
    wq1.delete();
    @(negedge clk);
    chk_reset_u1("midrst held");
    rst = 0;
    @(negedge clk);
    chk("after rst busy", busy1, 0);
    go(1, 0, 9'h011, 9'h1A0, 9'd1, '0, t0);
    at(t0 + 3);
    chk("restart done c4", done1, 1);
    wait_done(1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
